// File: rtl/vend_pkg.sv
// Shared constants for the cola vending controller.
//   - One-hot FSM state encodings (IDLE, CREDIT, VEND, CHANGE, REFUND)
//   - Coin values in 0.5-yuan credit units
package vend_pkg;

  localparam int unsigned NS = 5;

  localparam logic [NS-1:0] IDLE   = 5'b00001;
  localparam logic [NS-1:0] CREDIT = 5'b00010;
  localparam logic [NS-1:0] VEND   = 5'b00100;
  localparam logic [NS-1:0] CHANGE = 5'b01000;
  localparam logic [NS-1:0] REFUND = 5'b10000;

  localparam int unsigned COIN_05_U = 1;
  localparam int unsigned COIN_10_U = 2;

endpackage

// File: rtl/vend_pulse_gen.sv
// Change/refund motor pulse sequencer: one chg_pulse per 0.5-yuan unit,
// each pulse followed by CHG_GAP low cycles.
//   clk, rst_n  : clock, async active-low reset
//   start       : level, high while the controller is paying out
//   count       : credit units still owed
//   fire_c      : combinational, a pulse is issued this cycle (credit decrements)
//   chg_pulse   : registered motor pulse
//   done        : registered, high during the final pulse of the sequence
module vend_pulse_gen #(
  parameter int unsigned CW      = 4,
  parameter int unsigned CHG_GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          fire_c,
  output logic          chg_pulse,
  output logic          done
);

  localparam int unsigned GW = (CHG_GAP > 0) ? $clog2(CHG_GAP + 1) : 1;

  logic [GW-1:0] gap_q, gap_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;

  // Gap counter is held at zero while idle so the first pulse follows entry directly.
  always_comb begin
    gap_d   = gap_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    fire_c  = start && (gap_q == '0) && (count != '0);
    if (!start) begin
      gap_d = '0;
    end else if (fire_c) begin
      gap_d = GW'(CHG_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    pulse_d = fire_c;
    done_d  = fire_c && (count == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign chg_pulse = pulse_q;
  assign done      = done_q;

endmodule

// File: rtl/vend_ctrl.sv
// Cola vending sequencing controller: coin intake and credit, dispense
// handshake, change/refund payout, stock tracking and inactivity timeout.
//   clk, rst_n        : clock, async active-low reset
//   coin_05, coin_10  : one-cycle coin pulses (0.5 / 1.0 yuan)
//   refund_btn        : one-cycle refund request
//   disp_ack          : dispenser finished one can
//   disp_req          : dispense request, held until ack
//   chg_pulse         : one pulse returns one 0.5-yuan coin
//   coin_rej          : [0] reject coin_05, [1] reject coin_10
//   credit            : current credit in 0.5-yuan units
//   sold_out          : stock is empty
//   busy              : in VEND, CHANGE or REFUND
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 5,
  parameter int unsigned CW         = 4,
  parameter int unsigned CREDIT_MAX = 15,
  parameter int unsigned CHG_GAP    = 2,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned STOCK_INIT = 8,
  parameter int unsigned SW         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_05,
  input  logic          coin_10,
  input  logic          refund_btn,
  input  logic          disp_ack,
  output logic          disp_req,
  output logic          chg_pulse,
  output logic [1:0]    coin_rej,
  output logic [CW-1:0] credit,
  output logic          sold_out,
  output logic          busy
);

  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [NS-1:0] state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [SW-1:0] stock_q, stock_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    coin_rej_q, coin_rej_d;
  logic          disp_req_q, disp_req_d;
  logic          busy_q, busy_d;
  logic          sold_out_q, sold_out_d;

  logic          intake;
  logic          acc10, acc05;
  logic [CW1-1:0] sum10, sum05;
  logic [CW-1:0] cred_a, cred_b, rem;
  logic          pay_fire_c, pay_done;

  vend_pulse_gen #(
    .CW      (CW),
    .CHG_GAP (CHG_GAP)
  ) u_pulse (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     ((state_q == CHANGE) || (state_q == REFUND)),
    .count     (credit_q),
    .fire_c    (pay_fire_c),
    .chg_pulse (chg_pulse),
    .done      (pay_done)
  );

  // Next-state, credit, stock and timeout logic.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_d    = stock_q;
    to_d       = '0;
    coin_rej_d = 2'b00;

    // coin_10 is judged first; coin_05 then sees the updated credit.
    intake = ((state_q == IDLE) || (state_q == CREDIT)) && !sold_out_q;
    sum10  = {1'b0, credit_q} + CW1'(COIN_10_U);
    acc10  = coin_10 && intake && (sum10 <= CW1'(CREDIT_MAX));
    cred_a = acc10 ? sum10[CW-1:0] : credit_q;
    sum05  = {1'b0, cred_a} + CW1'(COIN_05_U);
    acc05  = coin_05 && intake && (sum05 <= CW1'(CREDIT_MAX));
    cred_b = acc05 ? sum05[CW-1:0] : cred_a;
    coin_rej_d = {coin_10 && !acc10, coin_05 && !acc05};

    rem = credit_q - CW'(PRICE);

    case (state_q)
      IDLE: begin
        credit_d = cred_b;
        if (acc10 || acc05) state_d = CREDIT;
      end
      CREDIT: begin
        credit_d = cred_b;
        to_d     = (acc10 || acc05) ? '0 : to_q + TW'(1);
        if (credit_q >= CW'(PRICE)) begin
          state_d = VEND;
        end else if (refund_btn) begin
          state_d = REFUND;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          state_d = REFUND;
        end
      end
      VEND: begin
        if (disp_ack) begin
          credit_d = rem;
          if (stock_q != '0) stock_d = stock_q - SW'(1);
          state_d = (rem != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE, REFUND: begin
        if (pay_fire_c) credit_d = credit_q - CW'(1);
        if (pay_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    disp_req_d = (state_d == VEND);
    busy_d     = (state_d == VEND) || (state_d == CHANGE) || (state_d == REFUND);
    sold_out_d = (stock_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      stock_q    <= SW'(STOCK_INIT);
      to_q       <= '0;
      coin_rej_q <= 2'b00;
      disp_req_q <= 1'b0;
      busy_q     <= 1'b0;
      sold_out_q <= (STOCK_INIT == 0);
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      to_q       <= to_d;
      coin_rej_q <= coin_rej_d;
      disp_req_q <= disp_req_d;
      busy_q     <= busy_d;
      sold_out_q <= sold_out_d;
    end
  end

  assign disp_req = disp_req_q;
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;
  assign sold_out = sold_out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl (PRICE=5, CHG_GAP=2, TIMEOUT=16, STOCK_INIT=2).
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_05 = 1'b0;
  logic       coin_10 = 1'b0;
  logic       refund_btn = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic       chg_pulse;
  logic [1:0] coin_rej;
  logic [3:0] credit;
  logic       sold_out;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  vend_ctrl #(
    .PRICE      (5),
    .CW         (4),
    .CREDIT_MAX (15),
    .CHG_GAP    (2),
    .TIMEOUT    (16),
    .STOCK_INIT (2),
    .SW         (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_05    (coin_05),
    .coin_10    (coin_10),
    .refund_btn (refund_btn),
    .disp_ack   (disp_ack),
    .disp_req   (disp_req),
    .chg_pulse  (chg_pulse),
    .coin_rej   (coin_rej),
    .credit     (credit),
    .sold_out   (sold_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Buys one can with exactly PRICE units: 2+2+1.
  task automatic vend_exact(input string tag, input logic exp_sold);
    coin_10 = 1'b1;
    step();
    step();
    coin_10 = 1'b0;
    coin_05 = 1'b1;
    step();
    coin_05 = 1'b0;
    chk({tag, "_credit5"}, credit, 5);
    chk({tag, "_busy_credit"}, busy, 0);
    step();
    chk({tag, "_req"}, disp_req, 1);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk({tag, "_req_drop"}, disp_req, 0);
    chk({tag, "_credit0"}, credit, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sold_out"}, sold_out, exp_sold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_disp_req", disp_req, 0);
    chk("rst_chg_pulse", chg_pulse, 0);
    chk("rst_coin_rej", coin_rej, 0);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sold_out", sold_out, 0);

    // 1: three coin_10, ack 3 cycles after request, one change pulse
    coin_10 = 1'b1;
    step();
    chk("s1_credit2", credit, 2);
    step();
    chk("s1_credit4", credit, 4);
    step();
    coin_10 = 1'b0;
    chk("s1_credit6", credit, 6);
    chk("s1_req_lo", disp_req, 0);
    step();
    chk("s1_req_c1", disp_req, 1);
    chk("s1_busy_vend", busy, 1);
    step();
    chk("s1_req_c2", disp_req, 1);
    step();
    chk("s1_req_c3", disp_req, 1);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("s1_req_fall", disp_req, 0);
    chk("s1_credit1", credit, 1);
    chk("s1_busy_change", busy, 1);
    chk("s1_pulse_lo", chg_pulse, 0);
    step();
    chk("s1_pulse", chg_pulse, 1);
    chk("s1_credit0", credit, 0);
    step();
    chk("s1_pulse_end", chg_pulse, 0);
    chk("s1_idle", busy, 0);
    chk("s1_sold_out", sold_out, 0);

    // 2: simultaneous coins twice
    do_reset();
    coin_05 = 1'b1;
    coin_10 = 1'b1;
    step();
    chk("s2_credit3", credit, 3);
    chk("s2_rej_a", coin_rej, 0);
    step();
    coin_05 = 1'b0;
    coin_10 = 1'b0;
    chk("s2_credit6", credit, 6);
    chk("s2_rej_b", coin_rej, 0);
    step();
    chk("s2_vend_req", disp_req, 1);
    chk("s2_vend_busy", busy, 1);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("s2_credit1", credit, 1);
    step();
    step();
    chk("s2_idle", busy, 0);

    // 3: credit 4 then refund; coin_10 during REFUND is rejected
    coin_10 = 1'b1;
    step();
    step();
    coin_10 = 1'b0;
    chk("s3_credit4", credit, 4);
    refund_btn = 1'b1;
    step();
    refund_btn = 1'b0;
    chk("s3_busy_entry", busy, 1);
    chk("s3_pulse_entry", chg_pulse, 0);
    coin_10 = 1'b1;
    step();
    coin_10 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s3_pulse%0d", k), chg_pulse, 1);
      chk($sformatf("s3_credit%0d", k), credit, 16'(3 - k));
      chk($sformatf("s3_busy%0d", k), busy, 1);
      if (k == 0) chk("s3_coin_rej", coin_rej, 2'b10);
      if (k < 3) begin
        step();
        chk($sformatf("s3_gap_a%0d", k), chg_pulse, 0);
        chk($sformatf("s3_gapbusy%0d", k), busy, 1);
        step();
        chk($sformatf("s3_gap_b%0d", k), chg_pulse, 0);
        step();
      end
    end
    step();
    chk("s3_idle", busy, 0);
    chk("s3_pulse_end", chg_pulse, 0);
    chk("s3_credit_end", credit, 0);

    // 4: inactivity timeout
    coin_05 = 1'b1;
    step();
    coin_05 = 1'b0;
    chk("s4_credit1", credit, 1);
    repeat (15) step();
    chk("s4_still_credit", busy, 0);
    step();
    chk("s4_refund", busy, 1);
    chk("s4_pulse_lo", chg_pulse, 0);
    step();
    chk("s4_pulse", chg_pulse, 1);
    chk("s4_credit0", credit, 0);
    step();
    chk("s4_idle", busy, 0);
    chk("s4_pulse_end", chg_pulse, 0);

    // 6: reset in the middle of CHANGE with credit 3
    do_reset();
    coin_05 = 1'b1;
    coin_10 = 1'b1;
    step();
    coin_05 = 1'b0;
    step();
    coin_05 = 1'b1;
    chk("s6_credit5", credit, 5);
    step();
    coin_05 = 1'b0;
    coin_10 = 1'b0;
    chk("s6_credit8", credit, 8);
    chk("s6_req", disp_req, 1);
    chk("s6_rej", coin_rej, 0);
    disp_ack = 1'b1;
    step();
    disp_ack = 1'b0;
    chk("s6_credit3", credit, 3);
    chk("s6_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_credit", credit, 0);
    chk("s6_rst_pulse", chg_pulse, 0);
    chk("s6_rst_req", disp_req, 0);
    chk("s6_rst_busy", busy, 0);
    step();
    rst_n = 1'b1;

    // 5: two exact vends empty the stock (also proves stock was restored to 2)
    vend_exact("s5_v1", 1'b0);
    vend_exact("s5_v2", 1'b1);
    coin_10 = 1'b1;
    step();
    coin_10 = 1'b0;
    chk("s5_rej", coin_rej, 2'b10);
    chk("s5_credit", credit, 0);
    chk("s5_busy", busy, 0);
    step();
    chk("s5_rej_end", coin_rej, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
